// File: rtl/switch_mcu_alu_sched.sv
// ALU unit sequencer: one-hot unit enable, shared cycle count and register-file port mux.
// Optional one-hot select checking: define SWITCH_MCU_ALU_SCHED_ONEHOT_CHK_EN.
module switch_mcu_alu_sched #(
  parameter int NUM_OP     = 8,
  parameter int LAST_CYCLE = 4
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic                  in_start,
  input  logic [NUM_OP-1:0]     in_op_sel,
  input  logic                  in_flush,
  output logic                  out_ready,
  output logic                  out_busy,
  output logic                  out_done,
  output logic [NUM_OP-1:0]     out_en,
  output logic [3:0]            out_cycle_cnt,
  input  logic [NUM_OP-1:0]     in_ren_vec,
  input  logic [NUM_OP*5-1:0]   in_raddr_vec,
  input  logic [NUM_OP-1:0]     in_wen_vec,
  input  logic [NUM_OP*5-1:0]   in_waddr_vec,
  input  logic [NUM_OP*32-1:0]  in_wdata_vec,
  output logic                  out_rf_ren,
  output logic [4:0]            out_rf_raddr,
  output logic                  out_rf_wen,
  output logic [4:0]            out_rf_waddr,
  output logic [31:0]           out_rf_wdata,
  output logic                  out_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(LAST_CYCLE);

  state_t             state_q;
  logic [NUM_OP-1:0]  op_q;
  logic [NUM_OP-1:0]  en_q;
  logic [3:0]         cnt_q;
  logic               done_q;
  logic               sel_ok;

`ifdef SWITCH_MCU_ALU_SCHED_ONEHOT_CHK_EN
  logic err_q;
  assign sel_ok  = $onehot(in_op_sel);
  assign out_err = err_q;
`else
  assign sel_ok  = (in_op_sel != '0);
  assign out_err = 1'b0;
`endif

  // Sequencer: accept in IDLE, count through RUN, one WB cycle, back to IDLE.
  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      en_q    <= '0;
      cnt_q   <= 4'd0;
      done_q  <= 1'b0;
`ifdef SWITCH_MCU_ALU_SCHED_ONEHOT_CHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef SWITCH_MCU_ALU_SCHED_ONEHOT_CHK_EN
      err_q  <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (in_start && !in_flush) begin
            if (sel_ok) begin
              op_q    <= in_op_sel;
              en_q    <= in_op_sel;
              cnt_q   <= 4'd1;
              state_q <= RUN;
            end else begin
`ifdef SWITCH_MCU_ALU_SCHED_ONEHOT_CHK_EN
              err_q   <= 1'b1;
`endif
            end
          end
        end
        RUN: begin
          if (in_flush) begin
            state_q <= IDLE;
            op_q    <= '0;
            en_q    <= '0;
            cnt_q   <= 4'd0;
          end else if (cnt_q == LAST_CNT) begin
            state_q <= WB;
            en_q    <= '0;
            cnt_q   <= 4'd0;
            done_q  <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + 4'd1;
          end
        end
        WB: begin
          state_q <= IDLE;
          op_q    <= '0;
          en_q    <= '0;
          cnt_q   <= 4'd0;
        end
        default: begin
          state_q <= IDLE;
          op_q    <= '0;
          en_q    <= '0;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

  logic        ren_c;
  logic [4:0]  raddr_c;
  logic        wen_c;
  logic [4:0]  waddr_c;
  logic [31:0] wdata_c;

  // AND-OR port mux; op_q is zero outside RUN/WB so idle ports read as zero.
  always_comb begin
    ren_c   = 1'b0;
    raddr_c = 5'd0;
    wen_c   = 1'b0;
    waddr_c = 5'd0;
    wdata_c = 32'd0;
    for (int k = 0; k < NUM_OP; k++) begin
      ren_c   = ren_c   | (op_q[k] & in_ren_vec[k]);
      raddr_c = raddr_c | (op_q[k] ? in_raddr_vec[5*k +: 5]  : 5'd0);
      wen_c   = wen_c   | (op_q[k] & in_wen_vec[k]);
      waddr_c = waddr_c | (op_q[k] ? in_waddr_vec[5*k +: 5]  : 5'd0);
      wdata_c = wdata_c | (op_q[k] ? in_wdata_vec[32*k +: 32] : 32'd0);
    end
  end

  assign out_ready     = !in_rst || (state_q == IDLE);
  assign out_busy      = in_rst && (state_q != IDLE);
  assign out_done      = done_q && !in_flush;
  assign out_en        = en_q;
  assign out_cycle_cnt = cnt_q;

  // Writes to x0 are dropped, and a flush in WB kills the pending write.
  assign out_rf_ren   = in_rst && ren_c;
  assign out_rf_raddr = in_rst ? raddr_c : 5'd0;
  assign out_rf_wen   = in_rst && wen_c && (waddr_c != 5'd0) && !in_flush;
  assign out_rf_waddr = in_rst ? waddr_c : 5'd0;
  assign out_rf_wdata = in_rst ? wdata_c : 32'd0;

endmodule

// File: tb/tb_switch_mcu_alu_sched.sv
// Randomized bench for switch_mcu_alu_sched against a phase-counting reference model.
module tb_switch_mcu_alu_sched;

  localparam int N = 8;
  localparam int L = 4;

`ifdef SWITCH_MCU_ALU_SCHED_ONEHOT_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic           in_clk = 1'b0;
  logic           in_rst = 1'b0;
  logic           in_start = 1'b0;
  logic [N-1:0]   in_op_sel = '0;
  logic           in_flush = 1'b0;
  logic           out_ready, out_busy, out_done;
  logic [N-1:0]   out_en;
  logic [3:0]     out_cycle_cnt;
  logic [N-1:0]   in_ren_vec = '0;
  logic [N*5-1:0] in_raddr_vec = '0;
  logic [N-1:0]   in_wen_vec = '0;
  logic [N*5-1:0] in_waddr_vec = '0;
  logic [N*32-1:0] in_wdata_vec = '0;
  logic           out_rf_ren, out_rf_wen, out_err;
  logic [4:0]     out_rf_raddr, out_rf_waddr;
  logic [31:0]    out_rf_wdata;

  switch_mcu_alu_sched #(.NUM_OP(N), .LAST_CYCLE(L)) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_start(in_start), .in_op_sel(in_op_sel),
    .in_flush(in_flush), .out_ready(out_ready), .out_busy(out_busy), .out_done(out_done),
    .out_en(out_en), .out_cycle_cnt(out_cycle_cnt), .in_ren_vec(in_ren_vec),
    .in_raddr_vec(in_raddr_vec), .in_wen_vec(in_wen_vec), .in_waddr_vec(in_waddr_vec),
    .in_wdata_vec(in_wdata_vec), .out_rf_ren(out_rf_ren), .out_rf_raddr(out_rf_raddr),
    .out_rf_wen(out_rf_wen), .out_rf_waddr(out_rf_waddr), .out_rf_wdata(out_rf_wdata),
    .out_err(out_err)
  );

  always #5 in_clk = ~in_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: m_t = 0 idle, 1..L executing with count m_t, L+1 write-back.
  int           m_t = 0;
  logic [N-1:0] m_sel = '0;
  logic         m_err = 1'b0;
  int           n_done = 0;
  int           n_wr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic cycle(input logic rs, input logic st, input logic [N-1:0] sel, input logic fl,
                       input int force_unit, input logic [4:0] f_waddr);
    logic [N-1:0] exp_en;
    logic [3:0]   exp_cnt;
    logic         exp_ren, exp_wen;
    logic [4:0]   exp_raddr, exp_waddr;
    logic [31:0]  exp_wdata;
    logic         mux_known;
    int           idx;
    @(negedge in_clk);
    in_rst = rs; in_start = st; in_op_sel = sel; in_flush = fl;
    for (int k = 0; k < N; k++) begin
      in_ren_vec[k]            = 1'($urandom);
      in_raddr_vec[5*k +: 5]   = 5'($urandom);
      in_wen_vec[k]            = 1'($urandom);
      in_waddr_vec[5*k +: 5]   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      in_wdata_vec[32*k +: 32] = $urandom;
    end
    if (force_unit >= 0) begin
      in_wen_vec[force_unit]             = 1'b1;
      in_ren_vec[force_unit]             = 1'b1;
      in_raddr_vec[5*force_unit +: 5]    = 5'd3;
      in_waddr_vec[5*force_unit +: 5]    = f_waddr;
      in_wdata_vec[32*force_unit +: 32]  = 32'h1;
    end
    #1;
    exp_en  = (m_t >= 1 && m_t <= L) ? m_sel : '0;
    exp_cnt = (m_t >= 1 && m_t <= L) ? 4'(m_t) : 4'd0;
    chk("ready", 32'(out_ready), 32'(!rs || m_t == 0));
    chk("busy",  32'(out_busy),  32'(rs && m_t != 0));
    chk("done",  32'(out_done),  32'(m_t == L + 1 && !fl));
    chk("en",    32'(out_en),    32'(exp_en));
    chk("cnt",   32'(out_cycle_cnt), 32'(exp_cnt));
    chk("err",   32'(out_err),   32'(m_err));
    mux_known = 1'b1;
    exp_ren = 1'b0; exp_wen = 1'b0; exp_raddr = 5'd0; exp_waddr = 5'd0; exp_wdata = 32'd0;
    if (rs && m_t != 0) begin
      if ($onehot(m_sel)) begin
        idx = 0;
        for (int k = 0; k < N; k++) if (m_sel[k]) idx = k;
        exp_ren   = in_ren_vec[idx];
        exp_raddr = in_raddr_vec[5*idx +: 5];
        exp_waddr = in_waddr_vec[5*idx +: 5];
        exp_wdata = in_wdata_vec[32*idx +: 32];
        exp_wen   = in_wen_vec[idx] && exp_waddr != 5'd0 && !fl;
      end else begin
        mux_known = 1'b0;
      end
    end
    if (mux_known) begin
      chk("rf_ren",   32'(out_rf_ren),   32'(exp_ren));
      chk("rf_raddr", 32'(out_rf_raddr), 32'(exp_raddr));
      chk("rf_wen",   32'(out_rf_wen),   32'(exp_wen));
      chk("rf_waddr", 32'(out_rf_waddr), 32'(exp_waddr));
      chk("rf_wdata", out_rf_wdata, exp_wdata);
    end
    if (out_done) n_done++;
    if (out_rf_wen) n_wr++;
    // Advance model across the coming rising edge.
    if (!rs) begin
      m_t = 0; m_sel = '0; m_err = 1'b0;
    end else begin
      m_err = 1'b0;
      if (m_t == 0) begin
        if (st && !fl) begin
          if (CHK ? $onehot(sel) : (sel != '0)) begin
            m_t = 1; m_sel = sel;
          end else if (CHK) begin
            m_err = 1'b1;
          end
        end
      end else if (m_t <= L) begin
        if (fl) begin m_t = 0; m_sel = '0; end
        else m_t = m_t + 1;
      end else begin
        m_t = 0; m_sel = '0;
      end
    end
  endtask

  initial begin
    logic [N-1:0] rsel;
    int           done_before;
    // Reset, then single instruction on unit 0.
    cycle(1'b0, 1'b0, '0, 1'b0, -1, 5'd0);
    cycle(1'b0, 1'b1, 8'h01, 1'b0, -1, 5'd0);
    cycle(1'b1, 1'b1, 8'h01, 1'b0, -1, 5'd0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, '0, 1'b0, 0, 5'd9);
    // Unit 2 write to r7, then to x0.
    cycle(1'b1, 1'b1, 8'h04, 1'b0, -1, 5'd0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, '0, 1'b0, 2, 5'd7);
    cycle(1'b1, 1'b1, 8'h04, 1'b0, -1, 5'd0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, '0, 1'b0, 2, 5'd0);
    // Start held high: accepted every L+2 cycles.
    done_before = n_done;
    for (int i = 0; i < 3 * (L + 2); i++) cycle(1'b1, 1'b1, 8'h10, 1'b0, 4, 5'd5);
    chk("held_start_dones", 32'(n_done - done_before), 32'd3);
    // Flush at count 2.
    cycle(1'b1, 1'b1, 8'h02, 1'b0, -1, 5'd0);
    cycle(1'b1, 1'b0, '0, 1'b0, 1, 5'd6);
    cycle(1'b1, 1'b0, '0, 1'b1, 1, 5'd6);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, '0, 1'b0, 1, 5'd6);
    // Multi-hot select and zero select.
    cycle(1'b1, 1'b1, 8'h03, 1'b0, -1, 5'd0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, '0, 1'b0, -1, 5'd0);
    cycle(1'b1, 1'b1, 8'h00, 1'b0, -1, 5'd0);
    cycle(1'b1, 1'b0, '0, 1'b0, -1, 5'd0);
    // Reset mid-run.
    cycle(1'b1, 1'b1, 8'h80, 1'b0, -1, 5'd0);
    cycle(1'b1, 1'b0, '0, 1'b0, -1, 5'd0);
    cycle(1'b0, 1'b0, '0, 1'b0, 7, 5'd4);
    cycle(1'b1, 1'b0, '0, 1'b0, 7, 5'd4);
    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 7))
        0:       rsel = '0;
        1:       rsel = N'($urandom);
        default: rsel = N'(1) << $urandom_range(0, N - 1);
      endcase
      cycle(($urandom_range(0, 99) != 0), 1'($urandom), rsel,
            ($urandom_range(0, 15) == 0), -1, 5'd0);
    end
    chk("saw_done", 32'(n_done > 0), 32'd1);
    chk("saw_write", 32'(n_wr > 0), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/switch_mcu_alu_sched.md
Name: switch_mcu_alu_sched

Overview:
- Sequencer and register-file port arbiter for the ALU execution units (sltiu, slti, addi, ...).
- Accepts one decoded instruction at a time and asserts exactly one unit enable.
- Drives the shared 4-bit cycle count seen by all units.
- Routes the enabled unit's read port and write port to the single register-file read/write interface.
- Sits between the decoder and the ALU unit array / register file.

Parameters:
- NUM_OP, 8, number of ALU units served (one-hot select width).
- LAST_CYCLE, 4, final execute cycle count value; legal range 1..15.

Ports:
- in_clk  input  1  system clock; all logic on rising edge.
- in_rst  input  1  reset, synchronous, active-low.
- in_start  input  1  decoder presents an instruction this cycle.
- in_op_sel  input  NUM_OP  one-hot unit select qualifying in_start.
- in_flush  input  1  synchronous abort of the current instruction.
- out_ready  output  1  scheduler idle and able to accept in_start.
- out_busy  output  1  instruction in flight (RUN or WB).
- out_done  output  1  one-cycle pulse in the WB cycle.
- out_en  output  NUM_OP  registered one-hot enable to units.
- out_cycle_cnt  output  4  registered cycle count to units.
- in_ren_vec  input  NUM_OP  per-unit read enable.
- in_raddr_vec  input  NUM_OP*5  per-unit read address, unit k at [5k+4:5k].
- in_wen_vec  input  NUM_OP  per-unit write enable.
- in_waddr_vec  input  NUM_OP*5  per-unit write address.
- in_wdata_vec  input  NUM_OP*32  per-unit write data, unit k at [32k+31:32k].
- out_rf_ren  output  1  register-file read enable.
- out_rf_raddr  output  5  register-file read address.
- out_rf_wen  output  1  register-file write enable.
- out_rf_waddr  output  5  register-file write address.
- out_rf_wdata  output  32  register-file write data.
- out_err  output  1  illegal select flag (optional feature only; tied 0 otherwise).

Behaviour:
- Reset: one clock, in_clk; synchronous active-low reset in_rst (sampled on rising edge when low).
- Reset values: state=IDLE, op_q=0, out_en=0, out_cycle_cnt=0, out_done=0, out_err=0.
- In reset, out_ready=1, out_busy=0 and all out_rf_* = 0.
- States: IDLE, RUN, WB.
- IDLE:
  - out_ready=1.
  - in_start=1: capture in_op_sel into op_q, out_en<=in_op_sel, out_cycle_cnt<=1, go to RUN.
  - in_start=1 with in_op_sel==0: ignored, stay IDLE.
- RUN:
  - out_en=op_q; out_cycle_cnt increments by 1 each cycle.
  - When out_cycle_cnt==LAST_CYCLE: next out_en<=0, out_cycle_cnt<=0, go to WB.
  - Unit write data registered at count LAST_CYCLE appears on in_*_vec during WB.
- WB:
  - out_done=1 for one cycle; next state IDLE.
  - op_q holds through WB for the port mux and clears on entry to IDLE.
  - Because out_en drops, units clear their wen after WB, giving a single-cycle write pulse.
- in_start while out_ready=0: ignored; the decoder must hold the instruction.
- Back-to-back: start accepted in the cycle after WB; latency is LAST_CYCLE+1 cycles from in_start to out_done.
- in_flush (RUN or WB): next cycle state=IDLE, out_en=0, out_cycle_cnt=0, op_q=0, no out_done.
  - Flush in the same cycle as WB suppresses out_rf_wen combinationally.
  - Flush has priority over in_start.
- Port mux:
  - Combinational AND-OR of in_*_vec masked by op_q.
  - Unselected units are ignored even if driving nonzero; op_q=0 gives all zeros.
- x0 protection: out_rf_wen = selected wen AND (waddr != 0).
- out_busy = state is RUN or WB; out_ready = state is IDLE.

Optional Feature:
- Macro: SWITCH_MCU_ALU_SCHED_ONEHOT_CHK_EN.
- Defined:
  - in_start in IDLE with in_op_sel not exactly one-hot (zero or more than one bit set) is rejected and the state stays IDLE.
  - out_err pulses 1 in the following cycle.
- Undefined:
  - out_err is constant 0.
  - Multi-hot selects are accepted as-is; the mux ORs them and the result is undefined by design.

Test Plan:
- Reset then in_start with in_op_sel=8'b0000_0001 -> out_en=1 with cycle counts 1,2,3,4; WB next; out_done pulse 5 cycles after start; out_ready returns to 1.
- Unit 0 drives ren=1, raddr=5'd3 while units 1..7 drive raddr=5'd31 -> out_rf_raddr=3 only while op_q=unit 0.
- Unit 2 writes waddr=5'd7, wdata=32'h1 during WB -> single-cycle out_rf_wen=1, waddr=7, wdata=1; same with waddr=0 -> out_rf_wen=0.
- in_start held high continuously -> new instruction accepted every 6 cycles; starts during RUN/WB ignored.
- in_flush at count 2 -> next cycle IDLE, out_en=0, count 0, no out_done, no rf write.
- With SWITCH_MCU_ALU_SCHED_ONEHOT_CHK_EN, in_op_sel=8'b0000_0011 -> stays IDLE, out_err=1 one cycle; without the macro -> accepted, out_err=0.
- in_rst low mid-RUN -> next edge all outputs at reset values.
